regb_dump_tx: RTL and testbench

Debug transmitter for the basic CPU: on a start request it walks register-file entries FIRST_REG..LAST_REG through a combinational read port and emits each register as two 8N1 UART frames on a single serial line. Frame order per register is the register index byte, then the register value byte. It sits beside the datapath's register bank and lets silicon or an FPGA board report R1..R3 the way a simulation bench prints them.

---
 rtl/regb_dump_tx_if.sv | 30 +++
 rtl/regb_dump_tx.sv | 126 ++++++++++++
 tb/tb_regb_dump_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regb_dump_tx_if.sv
// Bus bundle between the register-dump transmitter and its surroundings:
// dump request, register-file read port, serial line and status.
interface regb_dump_tx_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] rf_addr;
  logic [7:0]        rf_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  rf_data,
    output rf_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rf_data,
    input  rf_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/regb_dump_tx.sv
// Walks registers FIRST_REG..LAST_REG and sends each as two 8N1 UART frames:
// the register index byte, then the register value byte.
module regb_dump_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int ADDR_W       = 4,
  parameter int FIRST_REG    = 1,
  parameter int LAST_REG     = 3
) (
  input  logic           clk,
  input  logic           reset,
  regb_dump_tx_if.master bus
);
  localparam int                CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST_REG);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  typedef enum logic {INDEX, VALUE} phase_t;

  state_t            state, state_nxt;
  phase_t            phase, phase_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [7:0]        shift_q, shift_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic              done_q, done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= INDEX;
      idx     <= IDX_FIRST;
      shift_q <= 8'hFF;
      cnt     <= '0;
      bit_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      idx     <= idx_nxt;
      shift_q <= shift_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      done_q  <= done_nxt;
    end
  end

  // cnt times each serial bit; it only wraps on the last cycle of a bit
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    idx_nxt   = idx;
    shift_nxt = shift_q;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt   = IDX_FIRST;
        phase_nxt = INDEX;
        cnt_nxt   = '0;
        bit_nxt   = '0;
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        shift_nxt = (phase == INDEX) ? 8'(idx) : bus.rf_data;
        cnt_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = shift_q >> 1;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (phase == INDEX) begin
            phase_nxt = VALUE;
            state_nxt = LOAD;
          end else if (idx != IDX_LAST) begin
            idx_nxt   = idx + 1'b1;
            phase_nxt = INDEX;
            state_nxt = LOAD;
          end else begin
            idx_nxt   = IDX_FIRST;
            phase_nxt = INDEX;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level comes straight from state so reset forces idle without a clock
  always_comb begin
    case (state)
      START:   bus.tx = 1'b0;
      DATA:    bus.tx = shift_q[0];
      default: bus.tx = 1'b1;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.rf_addr = idx;
endmodule

// File: tb/tb_regb_dump_tx.sv
// Bench for regb_dump_tx: decodes the serial line of two differently
// parameterised instances and checks bytes, bit timing and handshake.
module tb_regb_dump_tx;
  localparam int C0 = 4, FIRST0 = 1, N0 = 3;
  localparam int C1 = 2, FIRST1 = 2, N1 = 1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   busy_cnt [2];
  int   n_compared = 0;
  int   n_failed = 0;
  logic [7:0] regs0 [16];
  logic [7:0] regs1 [16];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  regb_dump_tx_if #(.ADDR_W(4)) bus0 ();
  regb_dump_tx_if #(.ADDR_W(4)) bus1 ();

  regb_dump_tx #(.CLKS_PER_BIT(C0), .ADDR_W(4), .FIRST_REG(1), .LAST_REG(3)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  regb_dump_tx #(.CLKS_PER_BIT(C1), .ADDR_W(4), .FIRST_REG(2), .LAST_REG(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus0.rf_data = regs0[bus0.rf_addr];
  assign bus1.rf_data = regs1[bus1.rf_addr];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus0.busy) busy_cnt[0]++;
    if (bus1.busy) busy_cnt[1]++;
  end

  function automatic logic get_tx(input int inst);
    return (inst == 0) ? bus0.tx : bus1.tx;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic [3:0] get_addr(input int inst);
    return (inst == 0) ? bus0.rf_addr : bus1.rf_addr;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) bus0.start = v;
    else           bus1.start = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Samples on falling edges; every level must hold for a whole bit window
  task automatic recv_byte(input int inst, input int mut_reg, input logic [7:0] mut_val,
                           output logic [7:0] data, output int gap, output logic shape_ok,
                           output logic started);
    int   c;
    logic lvl;
    c        = (inst == 0) ? C0 : C1;
    data     = 8'h00;
    gap      = 0;
    shape_ok = 1'b1;
    lvl      = 1'b1;
    while (lvl && gap < 8 * c) begin
      @(negedge clk);
      lvl = get_tx(inst);
      if (lvl) gap++;
    end
    started = ~lvl;
    checkOutput($sformatf("frame_start_inst%0d", inst), {31'd0, lvl}, 32'd0);
    if (lvl) return;
    if (mut_reg >= 0) begin
      if (inst == 0) regs0[mut_reg] = mut_val;
      else           regs1[mut_reg] = mut_val;
    end
    for (int i = 1; i < c; i++) begin
      @(negedge clk);
      if (get_tx(inst) !== 1'b0) shape_ok = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      data[k] = get_tx(inst);
      for (int i = 1; i < c; i++) begin
        @(negedge clk);
        if (get_tx(inst) !== data[k]) shape_ok = 1'b0;
      end
    end
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      if (get_tx(inst) !== 1'b1) shape_ok = 1'b0;
    end
  endtask

  task automatic rx_and_compare(input int inst, input int exp_gap, input int mut_reg,
                                input logic [7:0] mut_val);
    logic [7:0] got;
    logic [7:0] want;
    int         gap;
    logic       shape_ok;
    logic       started;
    recv_byte(inst, mut_reg, mut_val, got, gap, shape_ok, started);
    if (!started) return;
    checkOutput("idle_gap_before_frame", gap, exp_gap);
    checkOutput("frame_bit_timing", {31'd0, shape_ok}, 32'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checkOutput($sformatf("byte_inst%0d", inst), {24'd0, got}, {24'd0, want});
  endtask

  // Called at a falling edge; the next rising edge samples start
  task automatic applyStimulus(input int inst, input logic hold, input int mut_byte,
                               input int mut_reg, input logic [7:0] mut_val);
    int c, first, n, start_cyc, frame_cycles;
    c     = (inst == 0) ? C0 : C1;
    first = (inst == 0) ? FIRST0 : FIRST1;
    n     = (inst == 0) ? N0 : N1;
    frame_cycles = 2 * n * (1 + 10 * c);
    set_start(inst, 1'b1);
    start_cyc = cyc;
    busy_cnt[inst] = 0;
    for (int r = first; r < first + n; r++) begin
      exp_q.push_back(8'(r));
      exp_q.push_back((inst == 0) ? regs0[r] : regs1[r]);
    end
    @(negedge clk);
    if (!hold) set_start(inst, 1'b0);
    checkOutput("busy_after_accept", {31'd0, get_busy(inst)}, 32'd1);
    checkOutput("done_low_after_accept", {31'd0, get_done(inst)}, 32'd0);
    for (int j = 0; j < 2 * n; j++)
      rx_and_compare(inst, (j == 0) ? 0 : 1, (j == mut_byte) ? mut_reg : -1, mut_val);
    @(negedge clk);
    checkOutput("done_at_end", {31'd0, get_done(inst)}, 32'd1);
    checkOutput("busy_low_at_done", {31'd0, get_busy(inst)}, 32'd0);
    checkOutput("rf_addr_at_done", {28'd0, get_addr(inst)}, first);
    checkOutput("done_cycle_count", cyc - start_cyc - 1, frame_cycles);
    checkOutput("busy_cycle_count", busy_cnt[inst], frame_cycles);
  endtask

  initial begin
    reset      = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    for (int i = 0; i < 16; i++) begin
      regs0[i] = 8'h00;
      regs1[i] = 8'h00;
    end
    regs0[1] = 8'h05;
    regs0[2] = 8'h07;
    regs0[3] = 8'h0C;
    regs1[2] = 8'hFF;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'd0, bus0.tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, bus0.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus0.done}, 32'd0);
    checkOutput("reset_rf_addr", {28'd0, bus0.rf_addr}, 32'd1);
    checkOutput("reset_rf_addr_inst1", {28'd0, bus1.rf_addr}, 32'd2);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single dump with one start pulse");
    applyStimulus(0, 1'b0, -1, -1, 8'h00);
    @(negedge clk);
    checkOutput("done_single_cycle", {31'd0, bus0.done}, 32'd0);
    checkOutput("idle_tx_high", {31'd0, bus0.tx}, 32'd1);

    $display("[TB] start held high across a dump, then back-to-back dump");
    applyStimulus(0, 1'b1, -1, -1, 8'h00);
    applyStimulus(0, 1'b0, -1, -1, 8'h00);
    repeat (3) @(negedge clk);

    $display("[TB] reset during data bits of byte 3");
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h05);
    rx_and_compare(0, 0, -1, 8'h00);
    rx_and_compare(0, 1, -1, 8'h00);
    repeat (1 + 3 * C0) @(negedge clk);
    checkOutput("rf_addr_before_reset", {28'd0, bus0.rf_addr}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", {31'd0, bus0.tx}, 32'd1);
    checkOutput("async_reset_busy", {31'd0, bus0.busy}, 32'd0);
    checkOutput("async_reset_rf_addr", {28'd0, bus0.rf_addr}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    applyStimulus(0, 1'b0, -1, -1, 8'h00);
    repeat (2) @(negedge clk);

    $display("[TB] rf_data changes right after the value load");
    applyStimulus(0, 1'b0, 3, 2, 8'h55);
    regs0[2] = 8'h07;
    repeat (2) @(negedge clk);

    $display("[TB] single-register instance, two clocks per bit");
    applyStimulus(1, 1'b0, -1, -1, 8'h00);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end
endmodule
